// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback requesters.
// Grant is combinational, the write lands 1 cycle later. Optional contention counter: REGFILE_WB_STALL_CNT_EN.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 hold,
   output logic                 RegWrite,
   output logic [AW-1:0]        wreg,
   output logic [DW-1:0]        wdata,
   output logic [(2**AW)-1:0]   pend_mask,
   output logic [31:0]          stall_cnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NR = 2**AW;

   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            regwrite_q, regwrite_d;
   logic [AW-1:0]   wreg_q, wreg_d;
   logic [DW-1:0]   wdata_q, wdata_d;

   logic [NREQ-1:0] grant;
   logic            grant_vld;
   logic [PW-1:0]   grant_idx;
   logic [AW-1:0]   grant_addr;
   logic [DW-1:0]   grant_data;
   int unsigned     scan_idx;
   logic [NR-1:0]   pend;

   // Scan starts at rr_ptr and wraps; the first valid requester found wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      if (!rst && !hold) begin
         for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_vld && req_valid[scan_idx]) begin
               grant_vld          = 1'b1;
               grant_idx          = PW'(scan_idx);
               grant[scan_idx]    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_addr = req_addr[int'(grant_idx)*AW +: AW];
      grant_data = req_data[int'(grant_idx)*DW +: DW];
   end

   // Writes to r0 are consumed but never reach the register file.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      regwrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      if (grant_vld) begin
         rr_ptr_d   = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + PW'(1);
         regwrite_d = |grant_addr;
         wreg_d     = grant_addr;
         wdata_d    = grant_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i]) pend[req_addr[i*AW +: AW]] = 1'b1;
      end
      if (regwrite_q) pend[wreg_q] = 1'b1;
      pend[0] = 1'b0;
   end

   assign req_ready = grant;
   assign RegWrite  = regwrite_q;
   assign wreg      = wreg_q;
   assign wdata     = wdata_q;
   assign pend_mask = pend;

`ifdef REGFILE_WB_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // A cycle counts as contention when someone valid is left waiting outside a hold.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!hold && (|(req_valid & ~grant)) && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= 32'h0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset corner sequences.
module tb_regfile_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   req_valid;
   logic [14:0]  req_addr;
   logic [95:0]  req_data;
   logic [2:0]   req_ready;
   logic         hold;
   logic         RegWrite;
   logic [4:0]   wreg;
   logic [31:0]  wdata;
   logic [31:0]  pend_mask;
   logic [31:0]  stall_cnt;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_stall = 32'h0;

`ifdef REGFILE_WB_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .hold(hold),
      .RegWrite(RegWrite), .wreg(wreg), .wdata(wdata),
      .pend_mask(pend_mask), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  vld;
      logic        hld;
      logic [4:0]  a0, a1, a2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  rdy;
      logic [31:0] pend;
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        chk_wd;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [2:0] vld, input logic hld,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [2:0] rdy, input logic [31:0] pend,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic chk_wd);
      vec_t v;
      v.vld = vld; v.hld = hld; v.a0 = a0; v.a1 = a1; v.a2 = a2;
      v.d0 = d0; v.d1 = d1; v.d2 = d2; v.rdy = rdy; v.pend = pend;
      v.we = we; v.wr = wr; v.wd = wd; v.chk_wd = chk_wd;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] vld, input logic hld,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      req_valid = vld;
      hold      = hld;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
   endtask

   // Requester protocol: a valid, unready request must stay valid with a stable address.
   logic [2:0]  prev_pend_req = 3'b000;
   logic [14:0] prev_addr = '0;
   logic        prev_rst = 1'b1;
   always @(negedge clk) begin
      if (!rst && !prev_rst && (prev_pend_req != 3'b000)) begin
         for (int i = 0; i < 3; i++) begin
            if (prev_pend_req[i]) begin
               tests++;
               if (!req_valid[i] || (req_addr[i*5 +: 5] != prev_addr[i*5 +: 5])) begin
                  fails++;
                  $display("FAIL protocol req%0d: valid=%0b addr=%0d, expected valid=1 addr=%0d",
                           i, req_valid[i], req_addr[i*5 +: 5], prev_addr[i*5 +: 5]);
               end
            end
         end
      end
      prev_pend_req <= req_valid & ~req_ready;
      prev_addr     <= req_addr;
      prev_rst      <= rst;
   end

   initial begin
      // vld hold a0 a1 a2 d0 d1 d2 | rdy pend | we wreg wdata chk
      add(3'b010, 0, 0, 8, 0, 0, 32'hDEAD_BEEF, 0, 3'b010, 32'h100, 1, 8, 32'hDEAD_BEEF, 1);
      add(3'b000, 0, 0, 8, 0, 0, 32'hDEAD_BEEF, 0, 3'b000, 32'h100, 0, 8, 32'hDEAD_BEEF, 1);
      add(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b100, 32'hE, 1, 3, 32'h33, 1);
      add(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 32'hE, 1, 1, 32'h11, 1);
      add(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b010, 32'hE, 1, 2, 32'h22, 1);
      add(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b100, 32'hE, 1, 3, 32'h33, 1);
      add(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 32'hE, 1, 1, 32'h11, 1);
      add(3'b111, 1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b000, 32'hE, 0, 1, 32'h11, 1);
      add(3'b111, 1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b000, 32'hE, 0, 1, 32'h11, 1);
      add(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b010, 32'hE, 1, 2, 32'h22, 1);
      add(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b100, 32'hE, 1, 3, 32'h33, 1);
      add(3'b011, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b001, 32'hE, 1, 1, 32'h11, 1);
      add(3'b010, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b010, 32'h6, 1, 2, 32'h22, 1);
      add(3'b000, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33, 3'b000, 32'h4, 0, 2, 32'h22, 1);
      add(3'b001, 0, 0, 0, 0, 32'h1234, 0, 0, 3'b001, 32'h0, 0, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0, 32'h1234, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0);
      add(3'b110, 0, 0, 9, 10, 0, 32'h99, 32'hAA, 3'b010, 32'h600, 1, 9, 32'h99, 1);
      add(3'b100, 0, 0, 9, 10, 0, 32'h99, 32'hAA, 3'b100, 32'h600, 1, 10, 32'hAA, 1);
      add(3'b011, 0, 5, 5, 10, 32'h1, 32'h2, 32'hAA, 3'b001, 32'h420, 1, 5, 32'h1, 1);
      add(3'b010, 0, 5, 5, 10, 32'h1, 32'h2, 32'hAA, 3'b010, 32'h20, 1, 5, 32'h2, 1);
      add(3'b000, 0, 5, 5, 10, 32'h1, 32'h2, 32'hAA, 3'b000, 32'h20, 0, 5, 32'h2, 1);
      add(3'b000, 0, 5, 5, 10, 32'h1, 32'h2, 32'hAA, 3'b000, 32'h0, 0, 5, 32'h2, 1);

      // Reset held two cycles with every requester valid.
      rst = 1'b1;
      drive(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33);
      @(posedge clk); #1;
      chk("reset ready c1", {29'h0, req_ready}, 32'h0);
      chk("reset RegWrite c1", {31'h0, RegWrite}, 32'h0);
      @(posedge clk); #1;
      chk("reset ready c2", {29'h0, req_ready}, 32'h0);
      chk("reset RegWrite c2", {31'h0, RegWrite}, 32'h0);
      chk("reset wreg", {27'h0, wreg}, 32'h0);
      chk("reset wdata", wdata, 32'h0);
      chk("reset stall_cnt", stall_cnt, 32'h0);
      rst = 1'b0;
      drive(3'b000, 0, 0, 0, 0, 0, 0, 0);

      for (int n = 0; n < vt.size(); n++) begin
         drive(vt[n].vld, vt[n].hld, vt[n].a0, vt[n].a1, vt[n].a2, vt[n].d0, vt[n].d1, vt[n].d2);
         #1;
         chk($sformatf("v%0d ready", n), {29'h0, req_ready}, {29'h0, vt[n].rdy});
         chk($sformatf("v%0d pend_mask", n), pend_mask, vt[n].pend);
         if (CNT_EN && !vt[n].hld && ((vt[n].vld & ~vt[n].rdy) != 3'b000))
            exp_stall = exp_stall + 32'd1;
         @(posedge clk); #1;
         chk($sformatf("v%0d RegWrite", n), {31'h0, RegWrite}, {31'h0, vt[n].we});
         if (vt[n].chk_wd) begin
            chk($sformatf("v%0d wreg", n), {27'h0, wreg}, {27'h0, vt[n].wr});
            chk($sformatf("v%0d wdata", n), wdata, vt[n].wd);
         end
         chk($sformatf("v%0d stall_cnt", n), stall_cnt, exp_stall);
      end

      // Reset while a write sits in the output stage; rr_ptr must restart at 0.
      drive(3'b001, 0, 4, 0, 0, 32'h44, 0, 0);
      #1;
      chk("midrst grant", {29'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
      chk("midrst inflight RegWrite", {31'h0, RegWrite}, 32'h1);
      chk("midrst inflight wreg", {27'h0, wreg}, 32'h4);
      rst = 1'b1;
      #1;
      chk("midrst ready during rst", {29'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      chk("midrst RegWrite dropped", {31'h0, RegWrite}, 32'h0);
      chk("midrst wreg cleared", {27'h0, wreg}, 32'h0);
      chk("midrst wdata cleared", wdata, 32'h0);
      chk("midrst stall_cnt cleared", stall_cnt, 32'h0);
      rst = 1'b0;
      drive(3'b111, 0, 1, 2, 3, 32'h11, 32'h22, 32'h33);
      #1;
      chk("post-rst rr_ptr=0 grant", {29'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
      chk("post-rst RegWrite", {31'h0, RegWrite}, 32'h1);
      chk("post-rst wdata", wdata, 32'h11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
